mult_div_unit: RTL

//  Iterative multiply/divide unit for the multicycle MIPS datapath; executes

---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit (mult, multu, div, divu) that holds HI/LO.
// Latency: done is high WIDTH+2 cycles after start (1 cycle for a divide by zero).
// Backpressure: none; start is taken only while idle, is ignored while busy, and is never queued.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start, op, a, b   request; op 00 mult, 01 multu, 10 div, 11 divu (sampled in IDLE)
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse; hi/lo are valid in the same cycle
//   div_by_zero       pulses with done when a divide had b == 0
//   hi, lo            mult: product high/low words; div: remainder/quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;     // mult: |multiplicand|; div: |divisor|
  logic               is_div;
  logic               neg_lo;   // negate product (mult) or quotient (div)
  logic               neg_hi;   // negate remainder (div only)
  logic               dbz;

  // Operand magnitudes; an unsigned W-bit magnitude holds |-2^(W-1)| exactly.
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  always_comb begin
    is_signed = ~op[0];
    mag_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // One iteration of either algorithm.
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_tmp;
  logic               no_borrow;
  logic [WIDTH-1:0]   sub_res;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole thing (with carry) right.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Restoring divide: bring the next dividend bit into the remainder.
    div_tmp   = acc[2*WIDTH-1:WIDTH-1];
    no_borrow = (div_tmp >= {1'b0, opnd});
    // When there is no borrow the difference is below the divisor, so W bits suffice.
    sub_res   = div_tmp[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_next = {(no_borrow ? sub_res : div_tmp[WIDTH-1:0]), acc[WIDTH-2:0], no_borrow};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_lo ? (~acc + 1'b1) : acc;
    quo_fix  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op[1] && (b == '0)) begin
              // Divide by zero: skip the datapath, hi/lo are left untouched.
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              count  <= '0;
              is_div <= op[1];
              if (op[1]) begin
                acc    <= {{WIDTH{1'b0}}, mag_a};
                opnd   <= mag_b;
                neg_lo <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi <= is_signed && a[WIDTH-1];
              end else begin
                acc    <= {{WIDTH{1'b0}}, mag_b};
                opnd   <= mag_a;
                neg_lo <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi <= 1'b0;
              end
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
        end
        default: begin  // DONE
          dbz   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign div_by_zero = dbz;

endmodule
